// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI NOR-flash target backed by a small internal byte
// memory. It decodes a command byte, a 24-bit address and data bytes arriving
// on s_mosi, and returns read data on s_miso. s_clk/s_css are oversampled in
// the p_clk domain.
//
// Ports:
//   p_clk        system clock (only clock)
//   p_reset      synchronous reset, active-high
//   s_clk        SPI clock from the master (asynchronous, synchronized here)
//   s_css        chip select, active-low (asynchronous, synchronized here)
//   s_mosi       byte from the master, valid at rising s_clk
//   s_miso       byte to the master
//   xfer_active  high while a transaction is being decoded
//   cmd_err      one-cycle pulse on an unknown command byte
//
// Optional feature macro: SPI_FLASH_READ_ID_EN -- accept command 0x9F (JEDEC
// read ID) and return FLASH_ID MSB first, then zeros until deselect.
//
// state  | meaning
// IDLE   | deselected, or waiting for a fresh s_css falling edge
// CMD    | waiting for the command byte
// ADDR   | shifting in three address bytes
// DATA   | write, read or ID burst until deselect
// IGNORE | unknown command, s_clk ignored until deselect
module spi_flash_responder #(
   parameter int          MEM_DEPTH = 16,
   parameter int          SPI_W     = 8,
   parameter logic [23:0] FLASH_ID  = 24'hEF4016
) (
   input  logic             p_clk,
   input  logic             p_reset,
   input  logic             s_clk,
   input  logic             s_css,
   input  logic [SPI_W-1:0] s_mosi,
   output logic [SPI_W-1:0] s_miso,
   output logic             xfer_active,
   output logic             cmd_err
);

`ifdef SPI_FLASH_READ_ID_EN
   localparam bit ID_EN = 1'b1;
`else
   localparam bit ID_EN = 1'b0;
`endif

   localparam int AW = $clog2(MEM_DEPTH);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
   typedef enum logic [1:0] {M_WRITE, M_READ, M_ID} mode_t;

   state_t           state, state_n;
   mode_t            mode, mode_n;
   logic [1:0]       byte_cnt, byte_cnt_n;
   logic [AW-1:0]    addr, addr_n;
   logic [SPI_W-1:0] miso_n;
   logic             cmd_err_n;
   logic             mem_we;

   logic [SPI_W-1:0] mem [MEM_DEPTH];

   logic             sclk_q1, sclk_q2, sclk_q3;
   logic             css_q1, css_q2, css_q3;
   logic [SPI_W-1:0] mosi_q1, mosi_s;
   logic             sclk_rise, css_rise, css_fall;

   // Chip-select sync flops reset to "selected" so that a select already held
   // low through reset produces no falling edge; decoding then waits for the
   // master to deselect and reselect.
   always_ff @(posedge p_clk) begin
      if (p_reset) begin
         sclk_q1 <= 1'b0;
         sclk_q2 <= 1'b0;
         sclk_q3 <= 1'b0;
         css_q1  <= 1'b0;
         css_q2  <= 1'b0;
         css_q3  <= 1'b0;
         mosi_q1 <= '0;
         mosi_s  <= '0;
      end else begin
         sclk_q1 <= s_clk;
         sclk_q2 <= sclk_q1;
         sclk_q3 <= sclk_q2;
         css_q1  <= s_css;
         css_q2  <= css_q1;
         css_q3  <= css_q2;
         mosi_q1 <= s_mosi;
         mosi_s  <= mosi_q1;
      end
   end

   assign sclk_rise = sclk_q2 & ~sclk_q3;
   assign css_rise  = css_q2 & ~css_q3;
   assign css_fall  = ~css_q2 & css_q3;

   always_comb begin
      state_n    = state;
      mode_n     = mode;
      byte_cnt_n = byte_cnt;
      addr_n     = addr;
      miso_n     = '0;
      cmd_err_n  = 1'b0;
      mem_we     = 1'b0;
      unique case (state)
         IDLE: begin
            if (css_fall) begin
               state_n    = CMD;
               byte_cnt_n = 2'd0;
            end
         end
         CMD: begin
            if (sclk_rise) begin
               byte_cnt_n = 2'd0;
               if (mosi_s == SPI_W'(8'h02)) begin
                  mode_n  = M_WRITE;
                  state_n = ADDR;
               end else if (mosi_s == SPI_W'(8'h01)) begin
                  mode_n  = M_READ;
                  state_n = ADDR;
               end else if (ID_EN && (mosi_s == SPI_W'(8'h9F))) begin
                  mode_n  = M_ID;
                  state_n = DATA;
               end else begin
                  state_n   = IGNORE;
                  cmd_err_n = 1'b1;
               end
            end
         end
         ADDR: begin
            // Memory is at most 256 bytes, so only the low bits of the last
            // address byte survive the modulo; earlier bytes are overwritten.
            if (sclk_rise) begin
               addr_n = mosi_s[AW-1:0];
               if (byte_cnt == 2'd2) begin
                  state_n    = DATA;
                  byte_cnt_n = 2'd0;
               end else begin
                  byte_cnt_n = byte_cnt + 2'd1;
               end
            end
         end
         DATA: begin
            case (mode)
               M_WRITE: begin
                  if (sclk_rise) begin
                     mem_we = 1'b1;
                     addr_n = addr + 1'b1;
                  end
               end
               M_READ: begin
                  if (sclk_rise) addr_n = addr + 1'b1;
                  // Look ahead to the next address so the new byte is
                  // registered one cycle after the master's edge.
                  miso_n = mem[addr_n];
               end
               M_ID: begin
                  if (sclk_rise && byte_cnt != 2'd3) byte_cnt_n = byte_cnt + 2'd1;
                  case (byte_cnt_n)
                     2'd0:    miso_n = SPI_W'(FLASH_ID[23:16]);
                     2'd1:    miso_n = SPI_W'(FLASH_ID[15:8]);
                     2'd2:    miso_n = SPI_W'(FLASH_ID[7:0]);
                     default: miso_n = '0;
                  endcase
               end
               default: ;
            endcase
         end
         IGNORE: ;
         default: state_n = IDLE;
      endcase
      // Deselect wins over a coincident s_clk edge: the byte is dropped.
      if (css_rise) begin
         state_n    = IDLE;
         mode_n     = mode;
         byte_cnt_n = byte_cnt;
         addr_n     = addr;
         miso_n     = '0;
         cmd_err_n  = 1'b0;
         mem_we     = 1'b0;
      end
      if (p_reset) mem_we = 1'b0;
   end

   always_ff @(posedge p_clk) begin
      if (p_reset) begin
         state    <= IDLE;
         mode     <= M_WRITE;
         byte_cnt <= 2'd0;
         addr     <= '0;
         s_miso   <= '0;
         cmd_err  <= 1'b0;
      end else begin
         state    <= state_n;
         mode     <= mode_n;
         byte_cnt <= byte_cnt_n;
         addr     <= addr_n;
         s_miso   <= miso_n;
         cmd_err  <= cmd_err_n;
      end
   end

   always_ff @(posedge p_clk) begin
      if (mem_we) mem[addr] <= mosi_s;
   end

   assign xfer_active = (state != IDLE);

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Synthesizable SPI NOR-flash target: the responder end of the byte-parallel SPI link driven by the APB NOR-flash controller.
- Decodes a command byte, a 24-bit address and data bytes on s_mosi, and returns read data on s_miso.
- Backed by a small internal byte memory.
- Used as an on-chip flash stand-in and as the loopback target in controller regression.

Parameters:
- MEM_DEPTH, 16, memory size in bytes (power of two, 4..256); address is taken modulo MEM_DEPTH.
- SPI_W, 8, s_mosi/s_miso width in bits.
- FLASH_ID, 24'hEF4016, three-byte JEDEC ID; used only with the optional feature.

Ports:
- p_clk  in  1  system clock; the only clock.
- p_reset  in  1  synchronous reset, active-high.
- s_clk  in  1  SPI clock from the master, sampled in the p_clk domain.
- s_css  in  1  chip select, active-low.
- s_mosi  in  SPI_W  byte from the master, valid at the rising edge of s_clk.
- s_miso  out  SPI_W  byte to the master.
- xfer_active  out  1  high while a transaction is being decoded.
- cmd_err  out  1  one-cycle pulse when an unknown command byte is received.

Behaviour:
- Reset (p_reset=1 at a p_clk rising edge):
  - s_miso=0, xfer_active=0, cmd_err=0, state=IDLE, byte counter=0, address=0.
  - Memory contents are not cleared.
- Input sampling:
  - s_clk and s_css pass through 2-flop synchronizers.
  - s_mosi is delayed 2 flops to stay aligned with them.
  - A rising-edge detect on synchronized s_clk produces one-cycle pulse sclk_rise.
  - The master holds s_clk high/low and s_mosi stable for at least 3 p_clk cycles each.
- States are IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE: synchronized s_css falling -> CMD; byte counter=0; xfer_active=1.
  - CMD: on sclk_rise, latch the command byte.
    - 0x02 (write) or 0x01 (read) -> ADDR.
    - Any other value -> IGNORE and pulse cmd_err.
  - ADDR: three sclk_rise pulses capture address[23:16], [15:8] and [7:0], MSB first, then -> DATA.
  - DATA, write: each sclk_rise writes s_mosi to mem[addr mod MEM_DEPTH], then addr+1.
  - DATA, read: s_miso = mem[addr]; on each sclk_rise, addr+1 and s_miso updates to the next byte.
  - IGNORE: all s_clk edges are ignored; s_miso=0.
- Read latency:
  - The first data byte appears on s_miso within 2 p_clk cycles of the 4th sclk_rise (last address byte).
  - Each later byte appears within 2 p_clk cycles of the previous sclk_rise.
  - The master samples each byte at its next rising s_clk.
- Address wrap: the increment is modulo MEM_DEPTH, so after the last byte it returns to 0. Unbounded burst length.
- s_css rising (synchronized), in any state:
  - -> IDLE in the next cycle; xfer_active=0; s_miso=0.
  - A partially received transaction is discarded; bytes already written remain written.
  - A CMD or ADDR phase cut short causes no memory write.
- Simultaneous s_css rise and sclk_rise in the same cycle: deselect wins and the byte is dropped.
- While s_css is high, s_clk activity is ignored.
- p_reset mid-transaction: returns to IDLE as above.
  - If s_css is still low when reset releases, the block waits for the next s_css falling edge before decoding.

Optional Feature:
- Macro: SPI_FLASH_READ_ID_EN.
- Defined:
  - Command 0x9F is accepted; CMD -> DATA, skipping ADDR.
  - s_miso presents FLASH_ID[23:16], [15:8] and [7:0] on successive bytes, with the same latency as a read.
  - After the third byte s_miso=0 until deselect.
- Undefined: 0x9F is an unknown command (-> IGNORE, cmd_err pulse).

Test Plan:
- Reset, then idle for 10 cycles -> s_miso=0x00, xfer_active=0, cmd_err=0.
- Write 0x02, addr 0x000000, data FF 00 FF 00, deselect -> mem[0..3]=FF,00,FF,00; xfer_active falls within 2 cycles of s_css high.
- Read 0x01, addr 0x000000, 4 data clocks -> s_miso sequence FF,00,FF,00, each byte valid before the next rising s_clk.
- Write 0x02, addr 0x00000E (MEM_DEPTH=16), data AA BB CC -> mem[14]=AA, mem[15]=BB, mem[0]=CC; read back from 0x00000E returns AA,BB,CC.
- Command 0x7E -> one-cycle cmd_err; following s_clk edges ignored; s_miso=0; memory unchanged.
- Write 0x02, addr 0x000004, s_css raised after the 2nd address byte -> no memory change, state IDLE. With SPI_FLASH_READ_ID_EN, command 0x9F -> s_miso EF,40,16.
